mod_updown_counter: RTL and testbench

- Parametrised successor to the team's N-bit synchronous up-counter.
- Adds a programmable modulus, up/down direction, synchronous load, and three run modes: wrap, saturate and one-shot.
- Primary use: iteration and bit-position control in the multiplier datapath, where the controller needs a "count K steps then signal done" primitive.
- Also usable as a general modulo counter elsewhere in the datapath.

---
 rtl/mod_updown_counter_pkg.sv | 15 +
 rtl/mod_updown_step.sv | 28 ++
 rtl/mod_updown_counter.sv | 116 +++++++++++
 tb/tb_mod_updown_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared multiplier-control constants for the up/down modulo counter.
// Run-mode codes and one-shot state encoding.
package mod_updown_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } os_state_e;

endpackage

// File: rtl/mod_updown_step.sv
// Combinational step unit: next modulo value and limit detect.
// Compares before stepping, so MODULUS = 2^N needs no extra bit.
module mod_updown_step
  import mod_updown_counter_pkg::*;
#(
  parameter int N       = 4,
  parameter int MODULUS = 16
) (
  input  logic [N-1:0] count,
  input  logic         up,
  output logic [N-1:0] stepValue,
  output logic         atLimit
);

  localparam logic [N:0]   MAX_W = (N+1)'(MODULUS - 1);
  localparam logic [N-1:0] MAX   = MAX_W[N-1:0];

  always_comb begin
    if (up) begin
      atLimit   = (count == MAX);
      stepValue = atLimit ? '0 : count + N'(1);
    end else begin
      atLimit   = (count == '0);
      stepValue = atLimit ? MAX : count - N'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with load and wrap/saturate/one-shot modes.
// All state lives here; the step unit is purely combinational.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int N       = 4,
  parameter int MODULUS = 16,
  parameter int MODE    = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         enable,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] loadValue,
  input  logic         start,
  output logic [N-1:0] count,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** N)) begin : g_bad_mod
      $error("MODULUS out of range 2..2^N");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("MODE must be 0, 1 or 2");
    end
  endgenerate

  localparam logic [N:0]   MAX_W = (N+1)'(MODULUS - 1);
  localparam logic [N-1:0] MAX   = MAX_W[N-1:0];

  logic [N-1:0] r_count;
  logic         r_ovf;
  os_state_e    r_state;

  logic [N-1:0] w_count_nxt;
  logic [N-1:0] w_step;
  logic [N-1:0] w_load_val;
  logic         w_ovf_nxt;
  logic         w_at_limit;
  os_state_e    w_state_nxt;

  mod_updown_step #(
    .N       (N),
    .MODULUS (MODULUS)
  ) u_step (
    .count     (r_count),
    .up        (up),
    .stepValue (w_step),
    .atLimit   (w_at_limit)
  );

  assign w_load_val = (loadValue > MAX) ? MAX : loadValue;

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_state_nxt = r_state;
    if (MODE == MODE_ONESHOT) begin
      unique case (r_state)
        IDLE: begin
          if (load) begin
            w_count_nxt = w_load_val;
          end else if (start) begin
            w_count_nxt = up ? '0 : MAX;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (load) begin
            w_count_nxt = w_load_val;
          end else if (enable) begin
            if (w_at_limit) w_state_nxt = DONE;
            else            w_count_nxt = w_step;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          if (load) w_count_nxt = w_load_val;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = IDLE;
      if (load) begin
        w_count_nxt = w_load_val;
      end else if (enable) begin
        w_ovf_nxt = w_at_limit;
        // saturate holds at the limit; wrap always takes the step
        if (!(MODE == MODE_SAT && w_at_limit))
          w_count_nxt = w_step;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign count    = r_count;
  assign overflow = r_ovf;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter across wrap/sat/one-shot.
// Expected results are queued at drive time and checked after the edge.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] loadValue;
  logic       start;

  logic [3:0] c_w, c_s, c_o, c_x;
  logic       o_w, o_s, o_o, o_x;
  logic       b_w, b_s, b_o, b_x;
  logic       d_w, d_s, d_o, d_x;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         sel;
    logic [3:0] c;
    logic       o;
    logic       b;
    logic       d;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mod_updown_counter #(.N(4), .MODULUS(10), .MODE(0)) u_wrap (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .load(load),
    .loadValue(loadValue), .start(start),
    .count(c_w), .overflow(o_w), .busy(b_w), .done(d_w));

  mod_updown_counter #(.N(4), .MODULUS(10), .MODE(1)) u_sat (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .load(load),
    .loadValue(loadValue), .start(start),
    .count(c_s), .overflow(o_s), .busy(b_s), .done(d_s));

  mod_updown_counter #(.N(4), .MODULUS(10), .MODE(2)) u_os (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .load(load),
    .loadValue(loadValue), .start(start),
    .count(c_o), .overflow(o_o), .busy(b_o), .done(d_o));

  mod_updown_counter #(.N(4), .MODULUS(16), .MODE(0)) u_w16 (
    .clk(clk), .clr(clr), .enable(enable), .up(up), .load(load),
    .loadValue(loadValue), .start(start),
    .count(c_x), .overflow(o_x), .busy(b_x), .done(d_x));

  function automatic logic [6:0] obs(input int sel);
    case (sel)
      0:       return {c_w, o_w, b_w, d_w};
      1:       return {c_s, o_s, b_s, d_s};
      2:       return {c_o, o_o, b_o, d_o};
      default: return {c_x, o_x, b_x, d_x};
    endcase
  endfunction

  task automatic push(input int sel, input logic [3:0] c,
                      input logic o, input logic b, input logic d,
                      input string tag);
    exp_t e;
    e.sel = sel; e.c = c; e.o = o; e.b = b; e.d = d; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [6:0] got;
    logic [6:0] want;
    e    = sb.pop_front();
    got  = obs(e.sel);
    want = {e.c, e.o, e.b, e.d};
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s inst=%0d got c=%0d o=%b b=%b d=%b want c=%0d o=%b b=%b d=%b",
             e.tag, e.sel, got[6:3], got[2], got[1], got[0],
             e.c, e.o, e.b, e.d);
    end
  endtask

  task automatic cyc(input int sel, input logic [3:0] c,
                     input logic o, input logic b, input logic d,
                     input string tag);
    push(sel, c, o, b, d, tag);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    clr = 1'b1; enable = 1'b0; up = 1'b1;
    load = 1'b0; loadValue = '0; start = 1'b0;
    #12;
    for (int i = 0; i < 4; i++) begin
      push(i, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
      check_now();
    end
    @(posedge clk); #1;
    clr = 1'b0;

    // wrap up-count from reset
    up = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 11; i++)
      cyc(0, 4'(i % 10), (i == 10), 1'b0, 1'b0, "wrap_up");

    enable = 1'b0;
    cyc(0, 4'd1, 1'b0, 1'b0, 1'b0, "hold_en0");

    // wrap down-count after load
    load = 1'b1; loadValue = 4'd2;
    cyc(0, 4'd2, 1'b0, 1'b0, 1'b0, "wrap_load2");
    load = 1'b0; up = 1'b0; enable = 1'b1;
    cyc(0, 4'd1, 1'b0, 1'b0, 1'b0, "wrap_dn1");
    cyc(0, 4'd0, 1'b0, 1'b0, 1'b0, "wrap_dn0");
    cyc(0, 4'd9, 1'b1, 1'b0, 1'b0, "wrap_dn9");
    cyc(0, 4'd8, 1'b0, 1'b0, 1'b0, "wrap_dn8");

    // saturate
    enable = 1'b0; load = 1'b1; loadValue = 4'd8;
    cyc(1, 4'd8, 1'b0, 1'b0, 1'b0, "sat_load8");
    load = 1'b0; up = 1'b1; enable = 1'b1;
    cyc(1, 4'd9, 1'b0, 1'b0, 1'b0, "sat_s1");
    cyc(1, 4'd9, 1'b1, 1'b0, 1'b0, "sat_s2");
    cyc(1, 4'd9, 1'b1, 1'b0, 1'b0, "sat_s3");
    cyc(1, 4'd9, 1'b1, 1'b0, 1'b0, "sat_s4");
    up = 1'b0;
    cyc(1, 4'd8, 1'b0, 1'b0, 1'b0, "sat_leave");

    // load clamp beats enable on the same edge
    up = 1'b1; enable = 1'b1; load = 1'b1; loadValue = 4'd12;
    cyc(0, 4'd9, 1'b0, 1'b0, 1'b0, "clamp_wrap");
    push(1, 4'd9, 1'b0, 1'b0, 1'b0, "clamp_sat");
    check_now();

    // full-range modulus 16
    enable = 1'b0; loadValue = 4'd15;
    cyc(3, 4'd15, 1'b0, 1'b0, 1'b0, "m16_load15");
    load = 1'b0; enable = 1'b1;
    cyc(3, 4'd0, 1'b1, 1'b0, 1'b0, "m16_wrap");
    cyc(3, 4'd1, 1'b0, 1'b0, 1'b0, "m16_next");

    // one-shot run, up
    enable = 1'b0; up = 1'b1; start = 1'b1;
    cyc(2, 4'd0, 1'b0, 1'b1, 1'b0, "os_start");
    start = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      start = (i == 4);
      cyc(2, 4'(i), 1'b0, 1'b1, 1'b0, "os_run");
    end
    start = 1'b0;
    cyc(2, 4'd9, 1'b0, 1'b0, 1'b1, "os_done");
    start = 1'b1;
    cyc(2, 4'd9, 1'b0, 1'b0, 1'b0, "os_done_start");
    start = 1'b0;
    cyc(2, 4'd9, 1'b0, 1'b0, 1'b0, "os_idle_hold");

    // async clear mid-run
    start = 1'b1;
    cyc(2, 4'd0, 1'b0, 1'b1, 1'b0, "os_start2");
    start = 1'b0;
    for (int i = 1; i <= 5; i++)
      cyc(2, 4'(i), 1'b0, 1'b1, 1'b0, "os_run2");
    #2;
    clr = 1'b1;
    #1;
    push(2, 4'd0, 1'b0, 1'b0, 1'b0, "os_async_clr");
    check_now();
    #1;
    clr = 1'b0;
    cyc(2, 4'd0, 1'b0, 1'b0, 1'b0, "os_idle_after");
    cyc(2, 4'd0, 1'b0, 1'b0, 1'b0, "os_no_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout checks=%0d want finish", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
